// File: rtl/spi_slave_rx_pkg.sv
// Shared types and constants for the SPI slave receiver.
package spi_slave_rx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int unsigned BITS_PER_BYTE = 8;
   localparam int unsigned BIT_CNT_W     = $clog2(BITS_PER_BYTE);

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pins and receive-side status bundle; slave modport is the receiver's view.
interface spi_slave_rx_if #(
   parameter int CNT_W = 16
);

   logic             spi_sclk_in;
   logic             spi_mosi_in;
   logic             spi_cs_n_in;
   logic             frame_start_out;
   logic             frame_end_out;
   logic             byte_rdy_out;
   logic [7:0]       byte_data_out;
   logic [CNT_W-1:0] byte_cnt_out;
   logic             err_out;

   modport slave (
      input  spi_sclk_in, spi_mosi_in, spi_cs_n_in,
      output frame_start_out, frame_end_out, byte_rdy_out,
             byte_data_out, byte_cnt_out, err_out
   );

   modport master (
      output spi_sclk_in, spi_mosi_in, spi_cs_n_in,
      input  frame_start_out, frame_end_out, byte_rdy_out,
             byte_data_out, byte_cnt_out, err_out
   );

endinterface

// File: rtl/spi_slave_rx_edge_sync.sv
// Two-flop synchronizer plus history flop; emits single-cycle rise/fall strobes.
module spi_edge_sync #(
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d_in,
   output logic level_out,
   output logic rise_out,
   output logic fall_out
);

   logic sync1;
   logic sync2;
   logic hist;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync1 <= IDLE_LVL;
         sync2 <= IDLE_LVL;
         hist  <= IDLE_LVL;
      end else begin
         sync1 <= d_in;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign level_out = sync2;
   assign rise_out  = sync2 & ~hist;
   assign fall_out  = ~sync2 & hist;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: frames on CS_n, assembles MSB-first bytes on SCLK rise.
// Optional SCLK inactivity abort is built when SPI_SLAVE_RX_TIMEOUT_EN is defined.
module spi_slave_rx
   import spi_slave_rx_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic            clk_in,
   input  logic            rst_in,
   spi_slave_rx_if.slave   bus
);

   logic sclk_rise;
   logic cs_rise;
   logic cs_fall;
   logic mosi_lvl;
   logic sclk_lvl;
   logic cs_lvl;

   state_t               state;
   state_t               state_nxt;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [BIT_CNT_W-1:0] bit_cnt_nxt;
   logic                 bit_wrap;
   logic [7:0]           shreg;
   logic [7:0]           byte_data;
   logic [CNT_W-1:0]     byte_cnt;
   logic                 byte_rdy;
   logic                 err;
   logic                 start;
   logic                 finish;
   logic                 timeout;

   spi_edge_sync #(.IDLE_LVL(1'b0)) u_sclk_sync (
      .clk_in(clk_in), .rst_in(rst_in), .d_in(bus.spi_sclk_in),
      .level_out(sclk_lvl), .rise_out(sclk_rise), .fall_out()
   );

   spi_edge_sync #(.IDLE_LVL(1'b1)) u_cs_sync (
      .clk_in(clk_in), .rst_in(rst_in), .d_in(bus.spi_cs_n_in),
      .level_out(cs_lvl), .rise_out(cs_rise), .fall_out(cs_fall)
   );

   spi_edge_sync #(.IDLE_LVL(1'b0)) u_mosi_sync (
      .clk_in(clk_in), .rst_in(rst_in), .d_in(bus.spi_mosi_in),
      .level_out(mosi_lvl), .rise_out(), .fall_out()
   );

`ifdef SPI_SLAVE_RX_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         tmo_cnt <= '0;
      end else if (state != SHIFT || sclk_rise) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   // Fires TIMEOUT cycles after the last SCLK strobe (counter is 0 one cycle after it).
   assign timeout = (state == SHIFT) && !sclk_rise && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      start       = 1'b0;
      finish      = 1'b0;
      bit_wrap    = 1'b0;
      bit_cnt_nxt = bit_cnt;
      if (sclk_rise) begin
         bit_wrap    = (bit_cnt == BIT_CNT_W'(BITS_PER_BYTE - 1));
         bit_cnt_nxt = bit_wrap ? '0 : bit_cnt + BIT_CNT_W'(1);
      end
      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_nxt = SHIFT;
               start     = 1'b1;
            end
         end
         SHIFT: begin
            if (cs_rise || timeout) begin
               state_nxt = IDLE;
               finish    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         byte_data <= '0;
         byte_cnt  <= '0;
         byte_rdy  <= 1'b0;
         err       <= 1'b0;
      end else begin
         state    <= state_nxt;
         byte_rdy <= 1'b0;
         if (start) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
         end else if (state == SHIFT) begin
            if (sclk_rise) begin
               shreg   <= {shreg[6:0], mosi_lvl};
               bit_cnt <= bit_cnt_nxt;
               if (bit_wrap) begin
                  byte_data <= {shreg[6:0], mosi_lvl};
                  byte_rdy  <= 1'b1;
                  if (byte_cnt != '1) begin
                     byte_cnt <= byte_cnt + CNT_W'(1);
                  end
               end
            end
            // A byte completing in the same cycle as the frame end is not partial.
            if (finish) begin
               bit_cnt <= '0;
               if (timeout || bit_cnt_nxt != '0) begin
                  err <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.frame_start_out = start;
   assign bus.frame_end_out   = finish;
   assign bus.byte_rdy_out    = byte_rdy;
   assign bus.byte_data_out   = byte_data;
   assign bus.byte_cnt_out    = byte_cnt;
   assign bus.err_out         = err;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: table of whole frames plus hand-written corner sequences.
module tb_spi_slave_rx;

   localparam int CNT_W = 2;
`ifdef SPI_SLAVE_RX_TIMEOUT_EN
   localparam int TB_TIMEOUT = 64;
`else
   localparam int TB_TIMEOUT = 1024;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_slave_rx_if #(.CNT_W(CNT_W)) bus ();

   spi_slave_rx #(.CNT_W(CNT_W), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk_in(clk),
      .rst_in(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_start = 0;
   int n_end   = 0;
   int n_rdy   = 0;
   int end_cyc = 0;
   int rdy_cyc = 0;
   logic [7:0] data_log[$];

   always @(negedge clk) begin
      if (bus.frame_start_out) n_start = n_start + 1;
      if (bus.frame_end_out) begin
         n_end   = n_end + 1;
         end_cyc = cyc;
      end
      if (bus.byte_rdy_out) begin
         n_rdy   = n_rdy + 1;
         rdy_cyc = cyc;
         data_log.push_back(bus.byte_data_out);
      end
   end

   int b_start, b_end, b_rdy;

   task automatic snap();
      b_start = n_start;
      b_end   = n_end;
      b_rdy   = n_rdy;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCLK period of eight clk_in cycles; MOSI changes while SCLK is low.
   task automatic send_bit(input logic b, output int rise_cyc);
      bus.spi_sclk_in = 1'b0;
      bus.spi_mosi_in = b;
      clk_n(4);
      bus.spi_sclk_in = 1'b1;
      rise_cyc = cyc;
      clk_n(4);
   endtask

   task automatic run_frame(input int nbits, input logic [39:0] bits);
      int rc;
      bus.spi_cs_n_in = 1'b0;
      clk_n(4);
      for (int i = 0; i < nbits; i++) send_bit(bits[39-i], rc);
      bus.spi_sclk_in = 1'b0;
      clk_n(4);
      bus.spi_cs_n_in = 1'b1;
      clk_n(8);
   endtask

   typedef struct {
      int          nbits;
      logic [39:0] bits;
      int          exp_rdy;
      logic [7:0]  exp_first;
      logic [7:0]  exp_data;
      int          exp_cnt;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int rc;
      int cnt_before;
      logic [7:0] pat;

      vecs[0] = '{16, 40'hA53C000000, 2, 8'hA5, 8'h3C, 2, 1'b0};
      vecs[1] = '{12, 40'h5AF0000000, 1, 8'h5A, 8'h5A, 1, 1'b1};
      vecs[2] = '{ 8, 40'hFF00000000, 1, 8'hFF, 8'hFF, 1, 1'b0};
      vecs[3] = '{ 0, 40'h0000000000, 0, 8'h00, 8'hFF, 0, 1'b0};
      vecs[4] = '{40, 40'h01807E55AA, 5, 8'h01, 8'hAA, 3, 1'b0};
      vecs[5] = '{ 9, 40'hC380000000, 1, 8'hC3, 8'hC3, 1, 1'b1};

      bus.spi_sclk_in = 1'b0;
      bus.spi_mosi_in = 1'b0;
      bus.spi_cs_n_in = 1'b1;
      clk_n(3);
      chk("reset_data", bus.byte_data_out, 8'h00);
      chk("reset_cnt", bus.byte_cnt_out, 0);
      chk("reset_err", bus.err_out, 1'b0);
      chk("reset_rdy", bus.byte_rdy_out, 1'b0);
      rst = 1'b0;
      clk_n(3);

      for (int v = 0; v < 6; v++) begin
         snap();
         run_frame(vecs[v].nbits, vecs[v].bits);
         chk($sformatf("v%0d_start", v), n_start - b_start, 1);
         chk($sformatf("v%0d_end", v), n_end - b_end, 1);
         chk($sformatf("v%0d_rdy", v), n_rdy - b_rdy, vecs[v].exp_rdy);
         if (vecs[v].exp_rdy > 0)
            chk($sformatf("v%0d_first", v), data_log[b_rdy], vecs[v].exp_first);
         chk($sformatf("v%0d_data", v), bus.byte_data_out, vecs[v].exp_data);
         chk($sformatf("v%0d_cnt", v), bus.byte_cnt_out, vecs[v].exp_cnt);
         chk($sformatf("v%0d_err", v), bus.err_out, vecs[v].exp_err);
      end

      // SCLK activity with CS_n high is ignored.
      snap();
      cnt_before = int'(bus.byte_cnt_out);
      for (int i = 0; i < 16; i++) send_bit(i[0], rc);
      bus.spi_sclk_in = 1'b0;
      clk_n(8);
      chk("idle_rdy", n_rdy - b_rdy, 0);
      chk("idle_start", n_start - b_start, 0);
      chk("idle_cnt", bus.byte_cnt_out, cnt_before);

      // 8th SCLK rise and CS_n rise land in the same synchronized cycle.
      snap();
      pat = 8'h6E;
      bus.spi_cs_n_in = 1'b0;
      clk_n(4);
      for (int i = 0; i < 7; i++) send_bit(pat[7-i], rc);
      bus.spi_sclk_in = 1'b0;
      bus.spi_mosi_in = pat[0];
      clk_n(4);
      bus.spi_sclk_in = 1'b1;
      bus.spi_cs_n_in = 1'b1;
      clk_n(8);
      bus.spi_sclk_in = 1'b0;
      clk_n(4);
      chk("same_end", n_end - b_end, 1);
      chk("same_rdy", n_rdy - b_rdy, 1);
      chk("same_rdy_after_end", rdy_cyc - end_cyc, 1);
      chk("same_data", bus.byte_data_out, 8'h6E);
      chk("same_cnt", bus.byte_cnt_out, 1);
      chk("same_err", bus.err_out, 1'b0);

      // CS_n glitch narrower than a clk_in period is never sampled.
      snap();
      @(posedge clk);
      #2 bus.spi_cs_n_in = 1'b0;
      #2 bus.spi_cs_n_in = 1'b1;
      clk_n(8);
      chk("glitch_start", n_start - b_start, 0);
      chk("glitch_end", n_end - b_end, 0);
      chk("glitch_data", bus.byte_data_out, 8'h6E);

      // Reset in the middle of a frame, then a clean frame.
      snap();
      bus.spi_cs_n_in = 1'b0;
      clk_n(4);
      for (int i = 0; i < 5; i++) send_bit(1'b1, rc);
      rst = 1'b1;
      #1;
      chk("midrst_data", bus.byte_data_out, 8'h00);
      chk("midrst_cnt", bus.byte_cnt_out, 0);
      chk("midrst_err", bus.err_out, 1'b0);
      chk("midrst_pulses", {bus.frame_start_out, bus.frame_end_out, bus.byte_rdy_out}, 3'b000);
      bus.spi_cs_n_in = 1'b1;
      bus.spi_sclk_in = 1'b0;
      clk_n(3);
      rst = 1'b0;
      clk_n(8);
      chk("midrst_no_end", n_end - b_end, 0);
      snap();
      run_frame(8, 40'h8100000000);
      chk("post_rst_data", bus.byte_data_out, 8'h81);
      chk("post_rst_cnt", bus.byte_cnt_out, 1);
      chk("post_rst_rdy", n_rdy - b_rdy, 1);

`ifdef SPI_SLAVE_RX_TIMEOUT_EN
      // SCLK stalls with CS_n low: abort exactly TIMEOUT cycles after last strobe.
      snap();
      bus.spi_cs_n_in = 1'b0;
      clk_n(4);
      for (int i = 0; i < 3; i++) send_bit(1'b1, rc);
      bus.spi_sclk_in = 1'b0;
      clk_n(100);
      chk("tmo_end", n_end - b_end, 1);
      chk("tmo_latency", end_cyc - rc, 2 + TB_TIMEOUT);
      chk("tmo_err", bus.err_out, 1'b1);
      for (int i = 0; i < 8; i++) send_bit(1'b1, rc);
      bus.spi_sclk_in = 1'b0;
      clk_n(8);
      chk("tmo_ignore_rdy", n_rdy - b_rdy, 0);
      chk("tmo_ignore_start", n_start - b_start, 1);
      bus.spi_cs_n_in = 1'b1;
      clk_n(8);
      chk("tmo_no_2nd_end", n_end - b_end, 1);
      snap();
      run_frame(8, 40'h3300000000);
      chk("tmo_recover_data", bus.byte_data_out, 8'h33);
      chk("tmo_recover_err", bus.err_out, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
